mux_hex_counter: RTL and testbench
==================================

# mux_hex_counter

Parametrised multi-digit up/down counter with synchronous load, count enable, hex or BCD digit mode, wrap-around terminal-count pulse, and a time-multiplexed common-anode seven-segment driver. It extends the single-digit 4-bit hex counter to DIGITS digits sharing one segment bus. It sits between board switches/buttons and the display pins.

## Interface
- CLK_HZ, 100_000_000: input clock frequency.
- COUNT_HZ, 1: count rate. DIV = CLK_HZ/COUNT_HZ, with DIV ≥ 2.
- SCAN_HZ, 1000: digit scan rate. SDIV = CLK_HZ/SCAN_HZ, with SDIV ≥ 1.
- DIGITS, 4: number of 4-bit digits, 1..8.
- BCD, 0: 0 = hex digits 0..F; 1 = decimal digits 0..9.

Ports:
- iClk  in  1  system clock; all logic on rising edge.
- inReset  in  1  synchronous, active-low reset.
- iLoad  in  1  synchronous parallel load.
- iCount_en  in  1  count enable.
- iUp  in  1  direction: 1 = up, 0 = down.
- iDP  in  DIGITS  per-digit decimal point, active-high; bit d belongs to digit d.
- iCount_in  in  4*DIGITS  load value; digit d is bits [4d+3:4d].
- oCount  out  4*DIGITS  current count, registered.
- oTC  out  1  one-cycle wrap pulse.
- oSSeg  out  8  segments, active-low: bit 7 = DP, bits [6:0] = g..a.
- oAnode  out  DIGITS  digit select, active-low one-hot.
- odiv_clock  out  1  divided count clock, registered.

## Operation
- Priority is reset > load > count.
- **Reset** (inReset=0 at an edge):
  - oCount=0, oTC=0, divider=0, odiv_clock=0, scan index=0.
  - oAnode=all 1, oSSeg=8'hFF (display blank).
- **Load** (iLoad=1):
  - oCount <= iCount_in at the next edge, regardless of iCount_en.
  - Divider restarts at 0. oTC=0.
  - BCD=1: any loaded digit >9 is stored as 9.
- **Count tick**: one-cycle internal strobe when divider = DIV-1. The divider wraps to 0 on the same edge.
- On a tick with iCount_en=1 and no load, the whole counter increments (iUp=1) or decrements (iUp=0).
  - Digit max is F (hex) or 9 (BCD).
  - Digit carry/borrow ripples to the next digit within the same edge.
- **Wrap**:
  - Up from all-max gives 0. Down from 0 gives all-max.
  - oTC=1 for exactly that one cycle, otherwise 0.
- iCount_en=0: oCount holds, but the divider and odiv_clock keep running.
- odiv_clock=1 while divider < DIV/2, else 0, so the count update coincides with its rising edge.
- **Scan**:
  - Scan index advances 0,1,…,DIGITS-1,0 every SDIV cycles.
  - oAnode[idx]=0 (all others 1).
  - oSSeg = {~iDP[idx], ~font(digit idx)}.
  - Digit 0 is the rightmost digit.
- **Font (active-high gfedcba before inversion)**:
  - 0: 3F, 1: 06, 2: 5B, 3: 4F, 4: 66, 5: 6D, 6: 7D, 7: 07
  - 8: 7F, 9: 6F, A: 77, b: 7C, C: 39, d: 5E, E: 79, F: 71

## Timing
- Load-to-oCount latency: 1 cycle.
- First tick after reset or load: DIV cycles later.
- oSSeg and oAnode are registered together, one cycle behind the scan index and count, so there is no tearing between anode and segments.
- The first digit is displayed on the cycle after reset deasserts.
- Simultaneous load and tick: load wins, and no oTC is produced.
- Reset mid-count: takes effect at the next edge; all outputs take their reset values.
- iUp and iCount_en are sampled only on tick cycles.

## Structure
- Package mux_hex_counter_pkg holds:
  - the 16-entry font constant;
  - the DIV and SDIV derivation functions;
  - the digit-max function selected by BCD.
- Sub-module rate_divider (parameter N; outputs tick and half-period level) is instantiated twice: once for the count tick/odiv_clock and once for the scan tick.
- Digit chain: generate loop over DIGITS, each stage a 4-bit digit with carry-in/carry-out.

## Test plan
Bench parameters: CLK_HZ=10, COUNT_HZ=1 (DIV=10), SCAN_HZ=5 (SDIV=2), DIGITS=2.
- **Reset**: inReset=0 for 3 cycles → oCount=8'h00, oTC=0, odiv_clock=0, oAnode=2'b11, oSSeg=8'hFF. Assert iLoad=1 together with reset → still 8'h00.
- **Hex up wrap** (BCD=0): load 8'hFE, iUp=1, iCount_en=1 → 8'hFF after 10 cycles, then 8'h00 after 10 more with oTC high for 1 cycle. Check odiv_clock period is 10 cycles.
- **BCD down wrap and clamp** (BCD=1):
  - Load 8'h00, iUp=0 → first tick gives 8'h99 with oTC=1, next tick gives 8'h98.
  - Load 8'h3C → oCount=8'h39.
- **Pause**: iCount_en=0 for 30 cycles at 8'h42 → oCount stays 8'h42, odiv_clock toggles 3 periods, oTC=0. Re-enable → 8'h43 on the next tick.
- **Scan**: oCount=8'h5A, iDP=2'b10 → oAnode alternates 2'b10 / 2'b01 every 2 cycles:
  - oSSeg=8'h88 while digit 0 (A) is selected;
  - oSSeg=8'h12 while digit 1 (5, DP on) is selected.
- **Load priority**: iLoad=1 on a tick cycle with iCount_en=1, iCount_in=8'h6F (hex) → oCount=8'h6F (not 8'h70), oTC=0, next update 10 cycles later.

Source files
------------

// File: rtl/mux_hex_counter_pkg.sv
// Shared constants and helpers for the multiplexed multi-digit counter:
// seven-segment font, divider derivation and per-mode digit limits.
package mux_hex_counter_pkg;

  // Active-high gfedcba patterns for glyphs 0..F (b and d lower case)
  localparam logic [6:0] FONT_ROM [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int calc_div(input int clk_hz, input int count_hz);
    return clk_hz / count_hz;
  endfunction

  function automatic int calc_sdiv(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

  function automatic logic [3:0] digit_max(input bit bcd);
    if (bcd) return 4'd9;
    else     return 4'hF;
  endfunction

  function automatic logic [3:0] clamp_digit(input bit bcd, input logic [3:0] d);
    if (bcd && (d > 4'd9)) return 4'd9;
    else                   return d;
  endfunction

  // Active-low segment byte: DP in bit 7, gfedcba below
  function automatic logic [7:0] seg_pattern(input logic dp, input logic [3:0] d);
    return {~dp, ~FONT_ROM[d]};
  endfunction

endpackage

// File: rtl/mux_hex_counter_rate_divider.sv
// Free-running modulo-N divider with a terminal-count strobe and a
// registered half-period level; restart forces the count back to zero.
module rate_divider #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick,
  output logic level
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  assign tick  = (cnt_q == CW'(N - 1));
  assign level = level_q;

  // Next count; level follows the new count so it rises on the wrap edge
  always_comb begin
    if (restart) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    level_d = (cnt_d < CW'(N / 2));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/mux_hex_counter.sv
// Multi-digit hex/BCD up/down counter with load, wrap pulse and a
// time-multiplexed common-anode seven-segment driver.
module mux_hex_counter
  import mux_hex_counter_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int COUNT_HZ = 1,
  parameter int SCAN_HZ  = 1000,
  parameter int DIGITS   = 4,
  parameter int BCD      = 0
) (
  input  logic                  iClk,
  input  logic                  inReset,
  input  logic                  iLoad,
  input  logic                  iCount_en,
  input  logic                  iUp,
  input  logic [DIGITS-1:0]     iDP,
  input  logic [4*DIGITS-1:0]   iCount_in,
  output logic [4*DIGITS-1:0]   oCount,
  output logic                  oTC,
  output logic [7:0]            oSSeg,
  output logic [DIGITS-1:0]     oAnode,
  output logic                  odiv_clock
);

  localparam int         DIV  = calc_div(CLK_HZ, COUNT_HZ);
  localparam int         SDIV = calc_sdiv(CLK_HZ, SCAN_HZ);
  localparam int         IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] DMAX = digit_max(BCD != 0);

  logic                  count_tick_s, scan_tick_s, div_level_s;
  logic [4*DIGITS-1:0]   count_q, count_d, next_count_s, load_value_s;
  logic                  tc_q, tc_d, wrap_s;
  logic [IDXW-1:0]       scan_idx_q, scan_idx_d;
  logic [DIGITS-1:0]     anode_q, anode_d;
  logic [7:0]            sseg_q, sseg_d;
  logic [3:0]            digit_s;
  logic                  dp_s;

  rate_divider #(.N(DIV)) u_count_div (
    .clk     (iClk),
    .rst_n   (inReset),
    .restart (iLoad),
    .tick    (count_tick_s),
    .level   (div_level_s)
  );

  rate_divider #(.N(SDIV)) u_scan_div (
    .clk     (iClk),
    .rst_n   (inReset),
    .restart (1'b0),
    .tick    (scan_tick_s),
    .level   ()
  );

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic [3:0] cur_s, nxt_s;
    logic       cin_s, cout_s;

    if (d == 0) begin : g_first
      assign cin_s = 1'b1;
    end else begin : g_rest
      assign cin_s = g_digit[d-1].cout_s;
    end

    assign cur_s = count_q[4*d +: 4];

    // One digit stage: carry/borrow in from the lower digit, out to the next
    always_comb begin
      nxt_s  = cur_s;
      cout_s = 1'b0;
      if (!cin_s) begin
        nxt_s = cur_s;
      end else if (iUp) begin
        if (cur_s >= DMAX) begin
          nxt_s  = 4'h0;
          cout_s = 1'b1;
        end else begin
          nxt_s = cur_s + 4'h1;
        end
      end else begin
        if (cur_s == 4'h0) begin
          nxt_s  = DMAX;
          cout_s = 1'b1;
        end else begin
          nxt_s = cur_s - 4'h1;
        end
      end
    end

    assign next_count_s[4*d +: 4] = nxt_s;
    assign load_value_s[4*d +: 4] = clamp_digit(BCD != 0, iCount_in[4*d +: 4]);
  end

  assign wrap_s = g_digit[DIGITS-1].cout_s;

  // Load beats a tick, so a load on a tick edge never raises the wrap pulse
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (iLoad) begin
      count_d = load_value_s;
    end else if (count_tick_s && iCount_en) begin
      count_d = next_count_s;
      tc_d    = wrap_s;
    end else begin
      count_d = count_q;
    end
  end

  // Scan index step and the display byte for the digit currently selected
  always_comb begin
    if (!scan_tick_s) begin
      scan_idx_d = scan_idx_q;
    end else if (scan_idx_q == IDXW'(DIGITS - 1)) begin
      scan_idx_d = '0;
    end else begin
      scan_idx_d = scan_idx_q + IDXW'(1);
    end
    digit_s = 4'h0;
    dp_s    = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (scan_idx_q == IDXW'(d)) begin
        digit_s = count_q[4*d +: 4];
        dp_s    = iDP[d];
      end else begin
        digit_s = digit_s;
      end
    end
    anode_d = ~(DIGITS'(1) << scan_idx_q);
    sseg_d  = seg_pattern(dp_s, digit_s);
  end

  always_ff @(posedge iClk) begin
    if (!inReset) begin
      count_q    <= '0;
      tc_q       <= 1'b0;
      scan_idx_q <= '0;
      anode_q    <= '1;
      sseg_q     <= 8'hFF;
    end else begin
      count_q    <= count_d;
      tc_q       <= tc_d;
      scan_idx_q <= scan_idx_d;
      anode_q    <= anode_d;
      sseg_q     <= sseg_d;
    end
  end

  assign oCount     = count_q;
  assign oTC        = tc_q;
  assign oAnode     = anode_q;
  assign oSSeg      = sseg_q;
  assign odiv_clock = div_level_s;

endmodule

// File: tb/tb_mux_hex_counter.sv
// Scoreboard bench: a hex and a BCD instance share stimulus; expectations
// are queued as stimulus is applied and drained after each sampled edge.
module tb_mux_hex_counter;

  logic       clk = 1'b0;
  logic       rst_n, load, en, up;
  logic [1:0] dp;
  logic [7:0] cin;

  logic [7:0] h_cnt, b_cnt, h_seg, b_seg;
  logic       h_tc, b_tc, h_div, b_div;
  logic [1:0] h_an, b_an;

  always #5 clk = ~clk;

  mux_hex_counter #(.CLK_HZ(10), .COUNT_HZ(1), .SCAN_HZ(5), .DIGITS(2), .BCD(0)) u_hex (
    .iClk(clk), .inReset(rst_n), .iLoad(load), .iCount_en(en), .iUp(up), .iDP(dp),
    .iCount_in(cin), .oCount(h_cnt), .oTC(h_tc), .oSSeg(h_seg), .oAnode(h_an),
    .odiv_clock(h_div)
  );

  mux_hex_counter #(.CLK_HZ(10), .COUNT_HZ(1), .SCAN_HZ(5), .DIGITS(2), .BCD(1)) u_bcd (
    .iClk(clk), .inReset(rst_n), .iLoad(load), .iCount_en(en), .iUp(up), .iDP(dp),
    .iCount_in(cin), .oCount(b_cnt), .oTC(b_tc), .oSSeg(b_seg), .oAnode(b_an),
    .odiv_clock(b_div)
  );

  typedef enum int {S_HCNT, S_HTC, S_HDIV, S_HAN, S_HSEG,
                    S_BCNT, S_BTC, S_BDIV, S_BAN, S_BSEG} sig_e;
  typedef struct {
    string      tag;
    sig_e       sig;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] observe(input sig_e s);
    case (s)
      S_HCNT:  return h_cnt;
      S_HTC:   return {7'd0, h_tc};
      S_HDIV:  return {7'd0, h_div};
      S_HAN:   return {6'd0, h_an};
      S_HSEG:  return h_seg;
      S_BCNT:  return b_cnt;
      S_BTC:   return {7'd0, b_tc};
      S_BDIV:  return {7'd0, b_div};
      S_BAN:   return {6'd0, b_an};
      S_BSEG:  return b_seg;
      default: return 8'hXX;
    endcase
  endfunction

  task automatic push_exp(input string tag, input sig_e s, input logic [7:0] e);
    exp_t item;
    item.tag = tag;
    item.sig = s;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  task automatic drain();
    exp_t item;
    while (sb_q.size() > 0) begin
      item = sb_q.pop_front();
      check_val(item.tag, observe(item.sig), item.exp);
    end
  endtask

  // Advance n edges; cyc counts edges since the last reset edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (!rst_n) cyc = 0;
      else        cyc++;
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    cin  = v;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic exp_counts(input string tag, input logic [7:0] hc, input logic ht,
                            input logic [7:0] bc, input logic bt);
    push_exp({tag, " hex cnt"}, S_HCNT, hc);
    push_exp({tag, " hex tc"},  S_HTC,  {7'd0, ht});
    push_exp({tag, " bcd cnt"}, S_BCNT, bc);
    push_exp({tag, " bcd tc"},  S_BTC,  {7'd0, bt});
  endtask

  // 20 cycles after a load: ticks land on k=10 and k=20
  task automatic run_window(input string tag,
                            input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] h2,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic ht1, input logic ht2, input logic bt1, input logic bt2);
    logic [7:0] hc, bc;
    logic       ht, bt;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      hc = (k < 10) ? h0 : (k < 20) ? h1 : h2;
      bc = (k < 10) ? b0 : (k < 20) ? b1 : b2;
      ht = (k == 10) ? ht1 : (k == 20) ? ht2 : 1'b0;
      bt = (k == 10) ? bt1 : (k == 20) ? bt2 : 1'b0;
      exp_counts($sformatf("%s k=%0d", tag, k), hc, ht, bc, bt);
      push_exp($sformatf("%s k=%0d odiv", tag, k), S_HDIV, 8'(((k % 10) < 5)));
      drain();
    end
  endtask

  initial begin
    int         rises;
    logic       prev;
    logic [1:0] an_exp;
    logic       sel1;

    rst_n = 1'b0; load = 1'b1; en = 1'b0; up = 1'b1; dp = 2'b00; cin = 8'hAB;
    step(3);
    exp_counts("reset", 8'h00, 1'b0, 8'h00, 1'b0);
    push_exp("reset hex odiv", S_HDIV, 8'h00);
    push_exp("reset bcd odiv", S_BDIV, 8'h00);
    push_exp("reset hex anode", S_HAN, 8'h03);
    push_exp("reset hex sseg", S_HSEG, 8'hFF);
    push_exp("reset bcd anode", S_BAN, 8'h03);
    push_exp("reset bcd sseg", S_BSEG, 8'hFF);
    drain();
    rst_n = 1'b1; load = 1'b0;
    step(2);

    up = 1'b1; en = 1'b1;
    do_load(8'hFE);
    exp_counts("load FE", 8'hFE, 1'b0, 8'h99, 1'b0);
    drain();
    run_window("up", 8'hFE, 8'hFF, 8'h00, 8'h99, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);

    up = 1'b0;
    do_load(8'h00);
    exp_counts("load 00", 8'h00, 1'b0, 8'h00, 1'b0);
    drain();
    run_window("down", 8'h00, 8'hFF, 8'hFE, 8'h00, 8'h99, 8'h98, 1'b1, 1'b0, 1'b1, 1'b0);

    do_load(8'h3C);
    exp_counts("clamp 3C", 8'h3C, 1'b0, 8'h39, 1'b0);
    drain();

    en = 1'b0; up = 1'b1;
    do_load(8'h42);
    rises = 0;
    prev  = h_div;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      exp_counts($sformatf("pause k=%0d", k), 8'h42, 1'b0, 8'h42, 1'b0);
      drain();
      if (h_div && !prev) rises++;
      prev = h_div;
    end
    check_val("pause odiv rises", 8'(rises), 8'd3);
    en = 1'b1;
    step(9);
    exp_counts("resume pre", 8'h42, 1'b0, 8'h42, 1'b0);
    drain();
    step(1);
    exp_counts("resume tick", 8'h43, 1'b0, 8'h43, 1'b0);
    drain();

    en = 1'b0; dp = 2'b10;
    do_load(8'h5A);
    exp_counts("scan load", 8'h5A, 1'b0, 8'h59, 1'b0);
    drain();
    step(2);
    for (int k = 0; k < 8; k++) begin
      step(1);
      sel1   = (((cyc - 1) / 2) % 2) == 1;
      an_exp = sel1 ? 2'b01 : 2'b10;
      push_exp($sformatf("scan hex anode cyc=%0d", cyc), S_HAN, {6'd0, an_exp});
      push_exp($sformatf("scan hex sseg cyc=%0d", cyc), S_HSEG, sel1 ? 8'h12 : 8'h88);
      push_exp($sformatf("scan bcd anode cyc=%0d", cyc), S_BAN, {6'd0, an_exp});
      push_exp($sformatf("scan bcd sseg cyc=%0d", cyc), S_BSEG, sel1 ? 8'h12 : 8'h90);
      drain();
    end

    en = 1'b1; up = 1'b1; dp = 2'b00;
    do_load(8'h10);
    step(9);
    exp_counts("prio pre", 8'h10, 1'b0, 8'h10, 1'b0);
    drain();
    do_load(8'h6F);
    exp_counts("prio load", 8'h6F, 1'b0, 8'h69, 1'b0);
    drain();
    step(9);
    exp_counts("prio hold", 8'h6F, 1'b0, 8'h69, 1'b0);
    drain();
    step(1);
    exp_counts("prio next", 8'h70, 1'b0, 8'h70, 1'b0);
    drain();

    step(3);
    rst_n = 1'b0;
    step(1);
    exp_counts("midreset", 8'h00, 1'b0, 8'h00, 1'b0);
    push_exp("midreset odiv", S_HDIV, 8'h00);
    push_exp("midreset anode", S_HAN, 8'h03);
    push_exp("midreset sseg", S_HSEG, 8'hFF);
    drain();
    rst_n = 1'b1;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
